// File: rtl/light_chaser_monitor.sv
`default_nettype none
// ============================================================================
// Module      : light_chaser_monitor
// Description : Receive-side checker for a one-hot rotating LED chaser bus.
//               Locks onto the rotate-left-by-1 sequence, reports the lit LED
//               index, a per-step pulse and a lap counter, and raises sticky
//               flags for non-one-hot patterns, out-of-order steps and wrong
//               dwell times.
// Ports       : clk, rst      - clock (rising edge), sync active-high reset
//               enable        - shared chaser enable; low freezes the monitor
//               light_in      - observed LED bus
//               err_clr       - single-cycle clear of the sticky error flags
//               position      - index of the lit LED (0 = LSB)
//               valid/locked  - position meaningful / rotation locked
//               step_pulse    - one pulse per accepted step while locked
//               lap_count     - accepted MSB->LSB wrap steps (mod 256)
//               err_onehot/err_order/err_timing - sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module light_chaser_monitor #(
  parameter int WIDTH       = 8,
  parameter int STEP_CYCLES = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [WIDTH-1:0]         light_in,
  input  logic                     err_clr,
  output logic [$clog2(WIDTH)-1:0] position,
  output logic                     valid,
  output logic                     locked,
  output logic                     step_pulse,
  output logic [7:0]               lap_count,
  output logic                     err_onehot,
  output logic                     err_order,
  output logic                     err_timing
);

  localparam int c_POS_W   = $clog2(WIDTH);
  // Dwell must be able to hold STEP_CYCLES+1 (the overrun marker).
  localparam int c_DWELL_W = $clog2(STEP_CYCLES + 2);
  localparam logic [c_DWELL_W-1:0] c_STEP = c_DWELL_W'(STEP_CYCLES);
  localparam logic [c_DWELL_W-1:0] c_SAT  = c_DWELL_W'(STEP_CYCLES + 1);

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_SYNC   = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       light_q;
  logic [c_DWELL_W-1:0]   dwell_q;
  logic [c_POS_W-1:0]     position_q, position_d;
  logic                   valid_q, locked_q, step_pulse_q, step_pulse_d;
  logic [7:0]             lap_count_q;
  logic                   err_onehot_q, err_order_q, err_timing_q;

  logic                   w_change, w_onehot, w_step, w_wrap, w_lap_inc;
  logic                   w_set_onehot, w_set_order, w_set_timing;
  logic [c_POS_W-1:0]     w_idx;
  logic [WIDTH-1:0]       w_rot;

  // Index of the highest set bit; only consumed when the input is one-hot.
  function automatic logic [c_POS_W-1:0] f_index(input logic [WIDTH-1:0] v);
    f_index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) f_index = c_POS_W'(i);
    end
  endfunction

  always_comb begin
    w_change = (light_in != light_q);
    w_onehot = (light_in != '0) && ((light_in & (light_in - 1'b1)) == '0);
    w_rot    = {light_q[WIDTH-2:0], light_q[WIDTH-1]};
    w_step   = (light_in == w_rot);
    w_wrap   = light_q[WIDTH-1];
    w_idx    = f_index(light_in);
  end

  // Next-state and event decode; all effects are gated by enable.
  always_comb begin
    state_d      = state_q;
    position_d   = position_q;
    step_pulse_d = 1'b0;
    w_lap_inc    = 1'b0;
    w_set_onehot = 1'b0;
    w_set_order  = 1'b0;
    w_set_timing = 1'b0;
    if (enable) begin
      case (state_q)
        S_HUNT: begin
          // HUNT inspects every active sample, changed or not.
          if (w_onehot) begin
            state_d    = S_SYNC;
            position_d = w_idx;
          end else begin
            w_set_onehot = 1'b1;
          end
        end
        S_SYNC: begin
          // First dwell after (re)sync is partial, so only order is checked.
          if (w_change) begin
            if (w_step) begin
              state_d    = S_LOCKED;
              position_d = w_idx;
            end else if (w_onehot) begin
              w_set_order = 1'b1;
              position_d  = w_idx;
            end else begin
              w_set_onehot = 1'b1;
              state_d      = S_HUNT;
            end
          end
        end
        S_LOCKED: begin
          if (w_change) begin
            if (w_step) begin
              position_d = w_idx;
              if (dwell_q == c_STEP) begin
                step_pulse_d = 1'b1;
                w_lap_inc    = w_wrap;
              end else begin
                w_set_timing = 1'b1;
                state_d      = S_SYNC;
              end
            end else if (w_onehot) begin
              w_set_order = 1'b1;
              position_d  = w_idx;
              state_d     = S_SYNC;
            end else begin
              w_set_onehot = 1'b1;
              state_d      = S_HUNT;
            end
          end else if (dwell_q == c_STEP) begin
            // This sample takes the dwell to STEP_CYCLES+1: overrun.
            w_set_timing = 1'b1;
            state_d      = S_SYNC;
          end
        end
        default: state_d = S_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_HUNT;
      light_q      <= '0;
      dwell_q      <= '0;
      position_q   <= '0;
      valid_q      <= 1'b0;
      locked_q     <= 1'b0;
      step_pulse_q <= 1'b0;
      lap_count_q  <= '0;
      err_onehot_q <= 1'b0;
      err_order_q  <= 1'b0;
      err_timing_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      position_q   <= position_d;
      valid_q      <= (state_d != S_HUNT);
      locked_q     <= (state_d == S_LOCKED);
      step_pulse_q <= step_pulse_d;
      if (w_lap_inc) lap_count_q <= lap_count_q + 8'd1;
      if (enable) begin
        if (w_change) begin
          light_q <= light_in;
          dwell_q <= c_DWELL_W'(1);
        end else if (dwell_q != c_SAT) begin
          dwell_q <= dwell_q + 1'b1;
        end
      end
      // A new error in the same cycle as err_clr still sets its flag.
      err_onehot_q <= w_set_onehot | (err_onehot_q & ~err_clr);
      err_order_q  <= w_set_order  | (err_order_q  & ~err_clr);
      err_timing_q <= w_set_timing | (err_timing_q & ~err_clr);
    end
  end

  assign position   = position_q;
  assign valid      = valid_q;
  assign locked     = locked_q;
  assign step_pulse = step_pulse_q;
  assign lap_count  = lap_count_q;
  assign err_onehot = err_onehot_q;
  assign err_order  = err_order_q;
  assign err_timing = err_timing_q;

endmodule
`default_nettype wire

// File: tb/tb_light_chaser_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_light_chaser_monitor
// Description : Directed self-checking bench for light_chaser_monitor with
//               WIDTH=8, STEP_CYCLES=5. Inputs change on the falling edge,
//               outputs are checked 1 time unit after the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_light_chaser_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] light_in;
  logic       err_clr;
  logic [2:0] position;
  logic       valid, locked, step_pulse;
  logic [7:0] lap_count;
  logic       err_onehot, err_order, err_timing;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  light_chaser_monitor #(.WIDTH(8), .STEP_CYCLES(5)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .light_in   (light_in),
    .err_clr    (err_clr),
    .position   (position),
    .valid      (valid),
    .locked     (locked),
    .step_pulse (step_pulse),
    .lap_count  (lap_count),
    .err_onehot (err_onehot),
    .err_order  (err_order),
    .err_timing (err_timing)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [7:0] l, input logic en, input logic clr, input logic r);
    @(negedge clk);
    light_in = l;
    enable   = en;
    err_clr  = clr;
    rst      = r;
    @(posedge clk);
    #1;
  endtask

  task automatic act(input logic [7:0] l);
    cyc(l, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic chk_err(input string tag, input logic oh, input logic ord, input logic tim);
    chk({tag, ".err_onehot"}, 32'(err_onehot), 32'(oh));
    chk({tag, ".err_order"},  32'(err_order),  32'(ord));
    chk({tag, ".err_timing"}, 32'(err_timing), 32'(tim));
  endtask

  // Apply one pattern for a full 5-cycle dwell while locked.
  task automatic hold_step(input logic [7:0] pat, input logic [2:0] pos,
                           input logic pulse, input logic [7:0] lap);
    act(pat);
    chk("step.pulse",  32'(step_pulse), 32'(pulse));
    chk("step.pos",    32'(position),   32'(pos));
    chk("step.locked", 32'(locked),     32'd1);
    chk("step.lap",    32'(lap_count),  32'(lap));
    repeat (4) begin
      act(pat);
      chk("hold.pulse", 32'(step_pulse), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] exp_lap;

    rst = 1'b1; enable = 1'b1; err_clr = 1'b0; light_in = 8'h00;

    // Reset with enable high and a garbage bus.
    cyc(8'h55, 1'b1, 1'b0, 1'b1);
    cyc(8'h03, 1'b1, 1'b0, 1'b1);
    chk("rst.pos",   32'(position),   32'd0);
    chk("rst.valid", 32'(valid),      32'd0);
    chk("rst.lock",  32'(locked),     32'd0);
    chk("rst.pulse", 32'(step_pulse), 32'd0);
    chk("rst.lap",   32'(lap_count),  32'd0);
    chk_err("rst", 1'b0, 1'b0, 1'b0);

    // ---- Clean sequence ----
    act(8'h01);
    chk("clean.sync.valid", 32'(valid),    32'd1);
    chk("clean.sync.lock",  32'(locked),   32'd0);
    chk("clean.sync.pos",   32'(position), 32'd0);
    repeat (4) act(8'h01);
    hold_step(8'h02, 3'd1, 1'b0, 8'd0);           // lock, no pulse
    exp_lap = 8'd0;
    for (int k = 2; k <= 9; k++) begin
      pat = 8'h01 << (k % 8);
      if (k % 8 == 0) exp_lap = exp_lap + 8'd1;
      hold_step(pat, 3'(k % 8), 1'b1, exp_lap);
    end
    chk("clean.lap", 32'(lap_count), 32'd1);
    chk_err("clean", 1'b0, 1'b0, 1'b0);

    // ---- Order error ----
    hold_step(8'h04, 3'd2, 1'b1, 8'd1);
    act(8'h10);
    chk("order.lock",  32'(locked),   32'd0);
    chk("order.valid", 32'(valid),    32'd1);
    chk("order.pos",   32'(position), 32'd4);
    chk_err("order", 1'b0, 1'b1, 1'b0);
    act(8'h20);
    chk("relock.lock",  32'(locked),     32'd1);
    chk("relock.pulse", 32'(step_pulse), 32'd0);
    chk("relock.pos",   32'(position),   32'd5);
    repeat (3) act(8'h20);
    cyc(8'h20, 1'b1, 1'b1, 1'b0);                 // 5th dwell cycle + clear
    chk_err("clr1", 1'b0, 1'b0, 1'b0);

    // ---- Short dwell ----
    act(8'h40);
    chk("short.pulse", 32'(step_pulse), 32'd1);
    act(8'h40);
    act(8'h40);
    act(8'h80);                                   // dwell was 3
    chk("short.lock",  32'(locked),   32'd0);
    chk("short.valid", 32'(valid),    32'd1);
    chk("short.pos",   32'(position), 32'd7);
    chk_err("short", 1'b0, 1'b0, 1'b1);
    act(8'h01);                                   // relock across wrap: no lap
    chk("wraplock.lock", 32'(locked),    32'd1);
    chk("wraplock.lap",  32'(lap_count), 32'd1);
    repeat (3) act(8'h01);
    cyc(8'h01, 1'b1, 1'b1, 1'b0);
    chk_err("clr2", 1'b0, 1'b0, 1'b0);

    // ---- Long dwell ----
    act(8'h02);
    chk("long.pulse", 32'(step_pulse), 32'd1);
    repeat (4) act(8'h02);
    chk("long.5th.tim", 32'(err_timing), 32'd0);
    act(8'h02);                                   // 6th cycle
    chk("long.6th.tim",  32'(err_timing), 32'd1);
    chk("long.6th.lock", 32'(locked),     32'd0);
    chk("long.6th.pos",  32'(position),   32'd1);
    act(8'h04);
    chk("long.relock", 32'(locked), 32'd1);
    repeat (3) act(8'h04);
    cyc(8'h04, 1'b1, 1'b1, 1'b0);
    chk_err("clr3", 1'b0, 1'b0, 1'b0);

    // ---- Enable gating ----
    act(8'h08);
    chk("gate.pulse0", 32'(step_pulse), 32'd1);
    act(8'h08);
    repeat (10) begin
      cyc(8'h08, 1'b0, 1'b0, 1'b0);
      chk("gate.idle.pulse", 32'(step_pulse), 32'd0);
    end
    chk("gate.idle.lock", 32'(locked), 32'd1);
    repeat (3) act(8'h08);
    act(8'h10);
    chk("gate.pulse1", 32'(step_pulse), 32'd1);
    chk("gate.pos",    32'(position),   32'd4);
    chk_err("gate", 1'b0, 1'b0, 1'b0);

    // ---- Bad pattern / HUNT ----
    act(8'h03);
    chk("bad03.valid", 32'(valid), 32'd0);
    chk_err("bad03", 1'b1, 1'b0, 1'b0);
    act(8'h00);
    chk("bad00.valid", 32'(valid),      32'd0);
    chk("bad00.oh",    32'(err_onehot), 32'd1);
    cyc(8'h00, 1'b1, 1'b1, 1'b0);                 // clear collides with new error
    chk("clrwin.oh", 32'(err_onehot), 32'd1);
    cyc(8'h04, 1'b1, 1'b1, 1'b0);
    chk("hunt04.valid", 32'(valid),      32'd1);
    chk("hunt04.pos",   32'(position),   32'd2);
    chk("hunt04.lock",  32'(locked),     32'd0);
    chk("hunt04.oh",    32'(err_onehot), 32'd0);

    // ---- Build lap_count up to 3 ----
    repeat (4) act(8'h04);
    hold_step(8'h08, 3'd3, 1'b0, 8'd1);
    exp_lap = 8'd1;
    for (int k = 4; k <= 16; k++) begin
      pat = 8'h01 << (k % 8);
      if (k % 8 == 0) exp_lap = exp_lap + 8'd1;
      hold_step(pat, 3'(k % 8), 1'b1, exp_lap);
    end
    chk("lap3", 32'(lap_count), 32'd3);

    // ---- Reset mid-lap ----
    act(8'h02);
    act(8'h02);
    cyc(8'h02, 1'b1, 1'b0, 1'b1);
    chk("mrst.pos",   32'(position),   32'd0);
    chk("mrst.valid", 32'(valid),      32'd0);
    chk("mrst.lock",  32'(locked),     32'd0);
    chk("mrst.pulse", 32'(step_pulse), 32'd0);
    chk("mrst.lap",   32'(lap_count),  32'd0);
    chk_err("mrst", 1'b0, 1'b0, 1'b0);
    act(8'h02);                                   // HUNT -> SYNC proves HUNT state
    chk("mrst.sync.valid", 32'(valid),    32'd1);
    chk("mrst.sync.lock",  32'(locked),   32'd0);
    chk("mrst.sync.pos",   32'(position), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/light_chaser_monitor.md
# light_chaser_monitor

Receive-side checker for the 8-LED light chaser bus. It samples the `light` vector driven by the chaser and locks onto the one-hot rotation. It then reports the current LED index, a per-step pulse and a lap count. It flags sticky errors for non-one-hot patterns, out-of-order steps and wrong dwell time. It sits beside the chaser on the LED bus and feeds status and debug logic.

## Interface
- `WIDTH`, 8: LED bus width; must be a power of two, at least 2.
- `STEP_CYCLES`, 5: enabled clocks each LED pattern is held by the chaser.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: same enable that drives the chaser. When low, the monitor freezes.
- `light_in` in WIDTH: LED bus under observation.
- `err_clr` in 1: single-cycle clear of all sticky error flags.
- `position` out log2(WIDTH): index of the lit LED; 0 = LSB.
- `valid` out 1: `position` is meaningful. High in SYNC and LOCKED.
- `locked` out 1: high in LOCKED only.
- `step_pulse` out 1: one-cycle pulse on each accepted step while LOCKED.
- `lap_count` out 8: count of accepted wrap steps (MSB to LSB). Wraps from 255 to 0.
- `err_onehot` out 1: sticky; a sampled pattern was not one-hot.
- `err_order` out 1: sticky; a one-hot change was not a rotate-left-by-1.
- `err_timing` out 1: sticky; the dwell differed from STEP_CYCLES while LOCKED.

## Operation
- Internal state:
  - `light_q`: last sampled pattern.
  - `dwell`: enabled cycles the pattern in `light_q` has been held. Saturates at STEP_CYCLES+1.
  - FSM state: HUNT, SYNC or LOCKED.
- A cycle is active only when `enable` is high. Inactive cycles change nothing, and `step_pulse` is 0 on them.
- On an active cycle, "change" means `light_in != light_q`.
- On a change, `light_q` loads `light_in` and `dwell` is set to 1. On no change, `dwell` increments.
- One-hot means exactly one bit is set. The value 0 is not one-hot.
- A valid step means `light_in` equals `light_q` rotated left by 1, so `1<<(WIDTH-1)` is followed by `1`.
- HUNT: on a one-hot `light_in`, go to SYNC and set `position`. On a non-one-hot `light_in`, stay in HUNT and set `err_onehot`.
- SYNC: the first dwell is partial, so it is not checked.
  - Valid step: go to LOCKED and update `position`. No `step_pulse` is issued.
  - Change to another one-hot value that is not a valid step: set `err_order` and stay in SYNC with the new position.
  - Change to a non-one-hot value: set `err_onehot` and go to HUNT.
- LOCKED, on a change:
  - Valid step with `dwell == STEP_CYCLES`:
    - pulse `step_pulse` and update `position`;
    - if the step wrapped from MSB to LSB, increment `lap_count`.
  - Valid step with `dwell != STEP_CYCLES`: set `err_timing`, go to SYNC and update `position`.
  - Non-valid one-hot change: set `err_order` and go to SYNC.
  - Non-one-hot change: set `err_onehot` and go to HUNT.
- LOCKED, on no change: if `dwell` reaches STEP_CYCLES+1, set `err_timing` and go to SYNC with `position` held.
- Sticky errors clear on `rst` or `err_clr`. If `err_clr` and a new error occur in the same cycle, the new error wins and its flag reads 1.
- `lap_count` is not cleared by `err_clr`.

## Timing
- All outputs are registered. Latency is 1 clock from the sampled `light_in` edge to `position`, `step_pulse`, state and flags.
- Reset values:
  - FSM state = HUNT;
  - `light_q` = 0, `dwell` = 0;
  - `position` = 0, `valid` = 0, `locked` = 0, `step_pulse` = 0;
  - `lap_count` = 0;
  - all error flags = 0.
- `rst` overrides `enable` and takes effect at the next edge, including mid-dwell or mid-lap.
- Against a chaser shifting every STEP_CYCLES enabled clocks:
  - lock occurs 1 cycle after the first observed step;
  - `step_pulse` then has a period of exactly STEP_CYCLES active cycles.
- When `enable` is low for N cycles, every step is delayed by N cycles. This is not an error, because `dwell` only counts active cycles.

## Test plan
- Clean sequence:
  - Stimulus: after `rst`, drive 0x01, 0x02, … 0x80, 0x01, 0x02, each held for 5 active cycles.
  - Required: `locked`=1 one cycle after 0x02 is sampled. `step_pulse` fires every 5 cycles. `position` runs 2…7,0,1. `lap_count`=1 after the 0x80→0x01 step. No error flags.
- Bad pattern:
  - Stimulus: from HUNT, drive 0x03 then 0x00.
  - Required: `err_onehot`=1 and `valid`=0; state stays HUNT.
  - Stimulus: drive 0x04.
  - Required: `valid`=1 and `position`=2.
- Order error:
  - Stimulus: while LOCKED at 0x04, drive 0x10.
  - Required: `err_order`=1, `locked`=0, `position`=4.
  - Stimulus: a valid 0x20 step follows.
  - Required: relock (`locked`=1) with no `step_pulse`.
- Timing errors:
  - Stimulus: while LOCKED, hold 0x08 for 3 cycles, then drive 0x10.
  - Required: `err_timing`=1 and state SYNC.
  - Stimulus: separately, hold a pattern for 6 cycles.
  - Required: `err_timing` set on the 6th cycle.
- Enable gating:
  - Stimulus: while LOCKED, drop `enable` for 10 cycles after 2 active cycles of 0x20, then resume for 3 more active cycles before stepping to 0x40.
  - Required: `step_pulse` fires and no errors are raised.
- Reset and clear:
  - Stimulus: `err_clr` asserted in the same cycle as a new non-one-hot sample.
  - Required: `err_onehot` reads 1.
  - Stimulus: `rst` asserted mid-lap with `lap_count`=3.
  - Required: next cycle, all outputs are at their reset values and the state is HUNT.
